// File: rtl/race_controller.sv
// rtl/race_controller.sv - Race game sequencer: lobby, countdown, race, finish hold and lane clear.
module race_controller #(
  parameter int MAX_POS         = 16,
  parameter int NB_PLAYERS      = 4,
  parameter int LOBBY_CYCLES    = 50_000_000,
  parameter int STEP_CYCLES     = 50_000_000,
  parameter int WIN_HOLD_CYCLES = 150_000_000,
  localparam int W = $clog2(MAX_POS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NB_PLAYERS-1:0]      ready_to_play,
  input  logic [NB_PLAYERS*W-1:0]    cur_pos,
  input  logic [NB_PLAYERS-1:0]      activity,
  output logic [1:0]                 current_screen,
  output logic                       players_reset,
  output logic [1:0]                 countdown,
  output logic [NB_PLAYERS-1:0]      winner,
  output logic                       any_activity
);

  localparam int LW = (LOBBY_CYCLES > 1) ? $clog2(LOBBY_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = (WIN_HOLD_CYCLES > 1) ? $clog2(WIN_HOLD_CYCLES) : 1;

  localparam logic [1:0] SCR_LOBBY     = 2'b00;
  localparam logic [1:0] SCR_COUNTDOWN = 2'b11;
  localparam logic [1:0] SCR_RACE      = 2'b01;
  localparam logic [1:0] SCR_FINISH    = 2'b10;

  typedef enum logic [2:0] {S_LOBBY, S_COUNTDOWN, S_RACE, S_FINISH, S_CLEAR} state_t;

  state_t                state;
  logic [NB_PLAYERS-1:0] ready_q;
  logic [NB_PLAYERS-1:0] finished;
  logic [NB_PLAYERS-1:0] first_finished;
  logic [LW-1:0]         lobby_timer;
  logic [SW-1:0]         step_timer;
  logic [HW-1:0]         hold_timer;
  logic                  ready_rise;

  assign ready_rise = |(ready_to_play & ~ready_q);

  // Descending scan so the lowest finished lane wins a simultaneous finish.
  always_comb begin
    finished       = '0;
    first_finished = '0;
    for (int i = 0; i < NB_PLAYERS; i++)
      finished[i] = ready_to_play[i] && (cur_pos[i*W +: W] == W'(MAX_POS - 1));
    for (int i = NB_PLAYERS - 1; i >= 0; i--) begin
      if (finished[i]) begin
        first_finished    = '0;
        first_finished[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_CLEAR;
      current_screen <= SCR_LOBBY;
      countdown      <= 2'd0;
      winner         <= '0;
      any_activity   <= 1'b0;
      players_reset  <= 1'b1;
      lobby_timer    <= '0;
      step_timer     <= '0;
      hold_timer     <= '0;
      ready_q        <= '0;
    end else begin
      ready_q       <= ready_to_play;
      any_activity  <= |activity;
      players_reset <= 1'b0;
      case (state)
        S_LOBBY: begin
          current_screen <= SCR_LOBBY;
          if (ready_rise || ready_to_play == '0) begin
            lobby_timer <= '0;
          end else if (lobby_timer == LW'(LOBBY_CYCLES - 1)) begin
            state          <= S_COUNTDOWN;
            current_screen <= SCR_COUNTDOWN;
            countdown      <= 2'd3;
            step_timer     <= '0;
            lobby_timer    <= '0;
          end else begin
            lobby_timer <= lobby_timer + LW'(1);
          end
        end
        S_COUNTDOWN: begin
          if (ready_to_play == '0) begin
            state          <= S_LOBBY;
            current_screen <= SCR_LOBBY;
            countdown      <= 2'd0;
            step_timer     <= '0;
            lobby_timer    <= '0;
          end else if (step_timer == SW'(STEP_CYCLES - 1)) begin
            step_timer <= '0;
            if (countdown == 2'd1) begin
              state          <= S_RACE;
              current_screen <= SCR_RACE;
              countdown      <= 2'd0;
            end else begin
              countdown <= countdown - 2'd1;
            end
          end else begin
            step_timer <= step_timer + SW'(1);
          end
        end
        S_RACE: begin
          if (|finished) begin
            winner         <= first_finished;
            state          <= S_FINISH;
            current_screen <= SCR_FINISH;
            hold_timer     <= '0;
          end
        end
        S_FINISH: begin
          if (hold_timer == HW'(WIN_HOLD_CYCLES - 1)) begin
            state          <= S_CLEAR;
            current_screen <= SCR_LOBBY;
            winner         <= '0;
            players_reset  <= 1'b1;
            hold_timer     <= '0;
          end else begin
            hold_timer <= hold_timer + HW'(1);
          end
        end
        S_CLEAR: begin
          state          <= S_LOBBY;
          current_screen <= SCR_LOBBY;
          lobby_timer    <= '0;
          step_timer     <= '0;
          hold_timer     <= '0;
        end
        default: begin
          state          <= S_CLEAR;
          current_screen <= SCR_LOBBY;
          countdown      <= 2'd0;
          winner         <= '0;
          players_reset  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_controller.sv
// tb/tb_race_controller.sv - Randomized and directed bench for race_controller against a phase/elapsed-time model.
module tb_race_controller;

  localparam int MAX_POS = 16;
  localparam int NB      = 4;
  localparam int LOBBY   = 8;
  localparam int STEP    = 4;
  localparam int HOLD    = 10;

  localparam int PH_LOBBY = 0;
  localparam int PH_CD    = 1;
  localparam int PH_RACE  = 2;
  localparam int PH_FIN   = 3;
  localparam int PH_CLEAR = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    ready_to_play;
  logic [15:0]   cur_pos;
  logic [3:0]    activity;
  logic [1:0]    current_screen;
  logic          players_reset;
  logic [1:0]    countdown;
  logic [3:0]    winner;
  logic          any_activity;

  int tests_run    = 0;
  int tests_failed = 0;

  int         m_phase;
  int         m_idle;
  int         m_elapsed;
  logic [3:0] m_winner;
  logic [3:0] m_prev;
  logic       m_act;

  race_controller #(
    .MAX_POS(MAX_POS), .NB_PLAYERS(NB), .LOBBY_CYCLES(LOBBY),
    .STEP_CYCLES(STEP), .WIN_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ready_to_play(ready_to_play), .cur_pos(cur_pos),
    .activity(activity), .current_screen(current_screen), .players_reset(players_reset),
    .countdown(countdown), .winner(winner), .any_activity(any_activity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] screen_of(input int ph);
    case (ph)
      PH_CD:   return 2'b11;
      PH_RACE: return 2'b01;
      PH_FIN:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = PH_CLEAR; m_idle = 0; m_elapsed = 0;
    m_winner = '0; m_prev = '0; m_act = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] fin;
    logic       rise;
    rise = |(ready_to_play & ~m_prev);
    fin  = '0;
    case (m_phase)
      PH_LOBBY: begin
        if (rise || ready_to_play == 4'd0) m_idle = 0;
        else if (m_idle == LOBBY - 1) begin m_phase = PH_CD; m_elapsed = 0; end
        else m_idle++;
      end
      PH_CD: begin
        if (ready_to_play == 4'd0) begin m_phase = PH_LOBBY; m_idle = 0; end
        else begin
          m_elapsed++;
          if (m_elapsed == 3 * STEP) m_phase = PH_RACE;
        end
      end
      PH_RACE: begin
        for (int i = 0; i < NB; i++)
          if (ready_to_play[i] && cur_pos[i*4 +: 4] == 4'(MAX_POS - 1)) fin[i] = 1'b1;
        if (fin != 4'd0) begin
          m_winner = fin & (~fin + 4'd1);
          m_phase = PH_FIN; m_elapsed = 0;
        end
      end
      PH_FIN: begin
        m_elapsed++;
        if (m_elapsed == HOLD) begin m_phase = PH_CLEAR; m_winner = '0; end
      end
      default: begin m_phase = PH_LOBBY; m_idle = 0; end
    endcase
    m_prev = ready_to_play;
    m_act  = |activity;
  endtask

  task automatic compare_all();
    check("screen", 32'(current_screen), 32'(screen_of(m_phase)));
    check("countdown", 32'(countdown), (m_phase == PH_CD) ? 32'(3 - m_elapsed / STEP) : 32'd0);
    check("winner", 32'(winner), 32'(m_winner));
    check("players_reset", 32'(players_reset), 32'(m_phase == PH_CLEAR));
    check("any_activity", 32'(any_activity), 32'(m_act));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_phase(input int ph, input int cd);
    int n;
    n = 0;
    while (!(m_phase == ph && (cd < 0 || (3 - m_elapsed / STEP) == cd)) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ready_to_play = '0; cur_pos = '0; activity = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_players_reset", 32'(players_reset), 32'd1);
    check("rst_screen", 32'(current_screen), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_countdown", 32'(countdown), 32'd0);
    reset_n = 1'b1;
    #1 check("release_players_reset", 32'(players_reset), 32'd1);
    tick();
    check("powerup_pr_low", 32'(players_reset), 32'd0);

    // Lobby to countdown to race timing
    ready_to_play = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    ready_to_play = 4'b0011;
    tick();
    n = 0;
    while (current_screen != 2'b11 && n < 50) begin tick(); n++; end
    check("lobby_to_cd_cycles", 32'(n), 32'd8);
    n = 0;
    while (current_screen != 2'b01 && n < 50) begin tick(); n++; end
    check("cd_to_race_cycles", 32'(n), 32'd12);

    // Lane 1 wins, finish hold, clear pulse
    tick();
    cur_pos[7:4] = 4'd15;
    tick();
    check("win_lane1", 32'(winner), 32'b0010);
    cur_pos = '0;
    n = 0;
    while (current_screen == 2'b10 && n < 50) begin tick(); n++; end
    check("finish_hold_cycles", 32'(n), 32'd10);
    check("clear_pulse", 32'(players_reset), 32'd1);
    tick();
    check("after_clear_pr", 32'(players_reset), 32'd0);
    check("after_clear_winner", 32'(winner), 32'd0);

    // Tie between lanes 0 and 2, lane 3 at goal but not ready
    ready_to_play = 4'b0111;
    wait_phase(PH_RACE, -1);
    cur_pos = 16'hFF0F;
    tick();
    check("tie_winner", 32'(winner), 32'b0001);
    cur_pos = '0;
    wait_phase(PH_LOBBY, -1);

    // Abort while countdown shows 2
    wait_phase(PH_CD, 2);
    ready_to_play = 4'b0000;
    tick();
    check("abort_screen", 32'(current_screen), 32'd0);
    check("abort_pr", 32'(players_reset), 32'd0);

    // Asynchronous reset in the middle of a race
    ready_to_play = 4'b0011;
    wait_phase(PH_RACE, -1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_screen", 32'(current_screen), 32'd0);
    check("async_pr", 32'(players_reset), 32'd1);
    check("async_winner", 32'(winner), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(31) == 0) ready_to_play = 4'($urandom);
      activity = 4'($urandom);
      for (int i = 0; i < NB; i++)
        cur_pos[i*4 +: 4] = ($urandom_range(7) == 0) ? 4'd15 : 4'($urandom_range(14));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/race_controller.md
RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 The block SHALL have parameter MAX_POS, default 16, meaning track length; player positions are 0..MAX_POS-1.
REQ-002 The block SHALL have parameter NB_PLAYERS, default 4, meaning number of player lanes.
REQ-003 The block SHALL have parameter LOBBY_CYCLES, default 50_000_000, meaning idle time after the last new ready player before the countdown starts.
REQ-004 The block SHALL have parameter STEP_CYCLES, default 50_000_000, meaning duration of each countdown step.
REQ-005 The block SHALL have parameter WIN_HOLD_CYCLES, default 150_000_000, meaning duration of the finish screen.
REQ-006 The block SHALL define localparam W = $clog2(MAX_POS).
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit, reset, asynchronous and active-low.
REQ-009 The block SHALL have port ready_to_play, input, NB_PLAYERS bits, per-player ready flag.
REQ-010 The block SHALL have port cur_pos, input, NB_PLAYERS*W bits, packed positions with player i at [i*W +: W].
REQ-011 The block SHALL have port activity, input, NB_PLAYERS bits, raw per-player button level, used for status only.
REQ-012 The block SHALL have port current_screen, output, 2 bits, encoded 00 LOBBY, 11 COUNTDOWN, 01 RACE, 10 FINISH.
REQ-013 The block SHALL have port players_reset, output, 1 bit, active-high synchronous clear for all player lanes.
REQ-014 The block SHALL have port countdown, output, 2 bits, giving 3/2/1 during COUNTDOWN and 0 otherwise.
REQ-015 The block SHALL have port winner, output, NB_PLAYERS bits, one-hot winning lane, all-zero when no winner.
REQ-016 The block SHALL have port any_activity, output, 1 bit, registered OR of activity.

Function
REQ-017 The FSM SHALL have states LOBBY, COUNTDOWN, RACE, FINISH, CLEAR; every output SHALL be registered.
REQ-018 In LOBBY, the block SHALL set screen=00 and run a W_l-bit timer.
REQ-019 The LOBBY timer SHALL clear to 0 on any cycle where a ready_to_play bit rises (0->1 versus its previous registered value) or when ready_to_play==0, and SHALL increment otherwise.
REQ-020 When LOBBY has ready_to_play!=0 and the timer equals LOBBY_CYCLES-1, the FSM SHALL go to COUNTDOWN with countdown=3 and the step timer=0.
REQ-021 In COUNTDOWN, screen SHALL be 11 (button presses ignored by lanes); countdown SHALL decrement every STEP_CYCLES cycles, 3->2->1.
REQ-022 After the step in which countdown=1 expires, the FSM SHALL go to RACE and set countdown=0.
REQ-023 In RACE, the FSM SHALL examine each lane i each cycle; lane i finishes when ready_to_play[i]=1 and cur_pos[i]==MAX_POS-1.
REQ-024 Lanes with ready_to_play[i]=0 SHALL be ignored for finishing.
REQ-025 On the first cycle of RACE with any finished lane, winner SHALL latch the lowest-index finished lane (simultaneous finishes resolve to the lowest index) and the FSM SHALL go to FINISH on the next edge.
REQ-026 In FINISH, screen SHALL be 10 and winner SHALL be held for WIN_HOLD_CYCLES cycles, after which the FSM SHALL go to CLEAR.
REQ-027 CLEAR SHALL last exactly 1 cycle with players_reset=1, screen=00, and winner cleared; the FSM SHALL then return to LOBBY with timers at 0.
REQ-028 players_reset SHALL be 0 in all states other than CLEAR.
REQ-029 If ready_to_play drops to 0 during COUNTDOWN, the FSM SHALL return to LOBBY (timer 0, countdown 0) with no players_reset.
REQ-030 Timers SHALL be wide enough for their own parameter ($clog2 of the value, minimum 1) and SHALL never wrap within a state.

Reset
REQ-031 While reset_n=0, the block SHALL hold state=CLEAR, current_screen=00, countdown=0, winner=0, any_activity=0, all timers 0, and players_reset=1.
REQ-032 On the first rising clk after reset_n rises, the block SHALL enter LOBBY and players_reset SHALL fall to 0.
REQ-033 Asserting reset_n low in any state, including mid-race, SHALL abort to these values immediately.

Verification
Parameters for all scenarios: MAX_POS=16, NB_PLAYERS=4, LOBBY_CYCLES=8, STEP_CYCLES=4, WIN_HOLD_CYCLES=10.
REQ-034 Power-up: release reset_n -> players_reset=1 until the first edge, then 0; screen=00.
REQ-035 Lobby/countdown: ready=0001, then 0011 after 5 cycles -> COUNTDOWN 8 cycles after the second rise; countdown shows 3,2,1 for 4 cycles each; screen=01 on cycle 12 of COUNTDOWN.
REQ-036 Win: in RACE, cur_pos[1] set to 15 with ready[1]=1 -> winner=0010 within 1 cycle; screen=10 for 10 cycles; then a 1-cycle players_reset; then LOBBY with winner=0000.
REQ-037 Tie and ignore: lanes 0 and 2 reach 15 on the same cycle, lane 3 at 15 with ready[3]=0 -> winner=0001.
REQ-038 Abort: ready falls to 0000 during countdown=2 -> LOBBY next edge, players_reset stays 0.
REQ-039 Mid-race reset: reset_n pulsed low in RACE -> screen=00 and players_reset=1 asynchronously, winner=0000.
